neuron_layer2_sequencer: RTL and testbench

//  Initiator side of the layer-2 neuron control interface. Accepts a stream of signed

---
 rtl/neuron_layer2_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_neuron_layer2_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer2_sequencer.sv
// Layer-2 neuron sequencer: accumulates signed synaptic-current words into a
// saturated membrane value, then sequences fire/leak, optional surrogate capture
// and surrogate readout for one neuron over a configurable number of timesteps.
module neuron_layer2_sequencer #(
   parameter int BIT_WIDTH_MEMBRANE  = 16,
   parameter int BIT_WIDTH_SURROGATE = 3,
   parameter int BIT_WIDTH_TIMESTEP  = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start_i,
   input  logic [BIT_WIDTH_TIMESTEP-1:0]  num_timesteps_i,
   input  logic                           training_state_i,
   input  logic [BIT_WIDTH_SURROGATE-1:0] surrogate_ref_i,
   input  logic                           cur_valid_i,
   output logic                           cur_ready_o,
   input  logic [BIT_WIDTH_MEMBRANE-1:0]  cur_data_i,
   input  logic                           cur_last_i,
   input  logic [BIT_WIDTH_MEMBRANE-1:0]  membrane_i,
   input  logic                           post_spike_i,
   input  logic [BIT_WIDTH_SURROGATE-1:0] surrogate_i,
   output logic [BIT_WIDTH_MEMBRANE-1:0]  membrane_update_o,
   output logic                           membrane_update_valid_o,
   output logic                           post_spiking_now_o,
   output logic                           this_sample_done_o,
   output logic                           training_state_o,
   output logic                           surrogate_compute_time_o,
   output logic                           surrogate_read_finish_o,
   output logic [BIT_WIDTH_SURROGATE-1:0] surrogate_ref_o,
   output logic                           spike_valid_o,
   output logic                           spike_o,
   output logic [BIT_WIDTH_TIMESTEP-1:0]  timestep_o,
   output logic                           surr_valid_o,
   input  logic                           surr_ready_i,
   output logic [BIT_WIDTH_SURROGATE-1:0] surr_data_o,
   output logic                           busy_o
);

   localparam int MEM = BIT_WIDTH_MEMBRANE;
   localparam int SUR = BIT_WIDTH_SURROGATE;
   localparam int TS  = BIT_WIDTH_TIMESTEP;

   localparam logic [MEM-1:0] MEM_MAX  = {1'b0, {(MEM-1){1'b1}}};
   localparam logic [MEM-1:0] MEM_MIN  = {1'b1, {(MEM-1){1'b0}}};
   localparam logic [MEM-1:0] MEM_ZERO = {MEM{1'b0}};
   localparam logic [SUR-1:0] SUR_ZERO = {SUR{1'b0}};
   localparam logic [TS-1:0]  TS_ZERO  = {TS{1'b0}};
   localparam logic [TS-1:0]  TS_ONE   = {{(TS-1){1'b0}}, 1'b1};

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LOAD   = 4'd1;
   localparam logic [3:0] S_ACCUM  = 4'd2;
   localparam logic [3:0] S_DRAIN  = 4'd3;
   localparam logic [3:0] S_FIRE   = 4'd4;
   localparam logic [3:0] S_SETTLE = 4'd5;
   localparam logic [3:0] S_SURR   = 4'd6;
   localparam logic [3:0] S_READ   = 4'd7;
   localparam logic [3:0] S_FINISH = 4'd8;

   logic [3:0]     state_r;
   logic [3:0]     state_s;
   logic [MEM-1:0] acc_r;
   logic [TS-1:0]  count_r;
   logic [TS-1:0]  steps_r;
   logic           training_r;
   logic           accept_s;
   logic           last_step_s;
   logic [MEM-1:0] acc_next_s;

   // Two's-complement add with one guard bit; clamps to the signed range on overflow.
   function automatic logic [MEM-1:0] sat_add(input logic [MEM-1:0] a, input logic [MEM-1:0] b);
      logic [MEM:0] sum;
      sum = {a[MEM-1], a} + {b[MEM-1], b};
      if (sum[MEM] != sum[MEM-1]) begin
         sat_add = sum[MEM] ? MEM_MIN : MEM_MAX;
      end else begin
         sat_add = sum[MEM-1:0];
      end
   endfunction

   // cur_ready_o is high exactly in ACCUM, so this is the accepted-word strobe.
   assign accept_s    = cur_ready_o & cur_valid_i;
   assign last_step_s = (count_r == (steps_r - TS_ONE));
   assign acc_next_s  = sat_add(acc_r, cur_data_i);

   // Feedback-dependent outputs are gated by their registered phase strobes.
   assign spike_o                 = spike_valid_o & post_spike_i;
   assign surr_data_o             = surr_valid_o ? surrogate_i : SUR_ZERO;
   assign surrogate_read_finish_o = surr_valid_o & surr_ready_i;

   // Next-state decode of the sample sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_i) begin
               state_s = S_LOAD;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_LOAD:  state_s = S_ACCUM;
         S_ACCUM: begin
            if (accept_s && cur_last_i) begin
               state_s = S_DRAIN;
            end else begin
               state_s = S_ACCUM;
            end
         end
         S_DRAIN: state_s = S_FIRE;
         S_FIRE:  state_s = S_SETTLE;
         S_SETTLE: begin
            if (last_step_s && training_r) begin
               state_s = S_SURR;
            end else if (last_step_s) begin
               state_s = S_FINISH;
            end else begin
               state_s = S_LOAD;
            end
         end
         S_SURR: state_s = S_READ;
         S_READ: begin
            if (surr_ready_i) begin
               state_s = S_FINISH;
            end else begin
               state_s = S_READ;
            end
         end
         S_FINISH: state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // State, datapath and registered phase outputs decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r                  <= S_IDLE;
         acc_r                    <= MEM_ZERO;
         count_r                  <= TS_ZERO;
         steps_r                  <= TS_ZERO;
         training_r               <= 1'b0;
         cur_ready_o              <= 1'b0;
         membrane_update_o        <= MEM_ZERO;
         membrane_update_valid_o  <= 1'b0;
         post_spiking_now_o       <= 1'b0;
         this_sample_done_o       <= 1'b0;
         training_state_o         <= 1'b0;
         surrogate_compute_time_o <= 1'b0;
         surrogate_ref_o          <= SUR_ZERO;
         spike_valid_o            <= 1'b0;
         timestep_o               <= TS_ZERO;
         surr_valid_o             <= 1'b0;
         busy_o                   <= 1'b0;
      end else begin
         state_r <= state_s;

         if ((state_r == S_IDLE) && start_i) begin
            steps_r    <= (num_timesteps_i == TS_ZERO) ? TS_ONE : num_timesteps_i;
            training_r <= training_state_i;
            count_r    <= TS_ZERO;
         end else if ((state_r == S_SETTLE) && !last_step_s) begin
            count_r <= count_r + TS_ONE;
         end else begin
            count_r <= count_r;
         end

         if (state_r == S_LOAD) begin
            acc_r <= membrane_i;
         end else if (accept_s) begin
            acc_r <= acc_next_s;
         end else begin
            acc_r <= acc_r;
         end

         // Update is presented for exactly one cycle after each accepted word.
         membrane_update_valid_o <= accept_s;
         if (accept_s) begin
            membrane_update_o <= acc_next_s;
         end else begin
            membrane_update_o <= membrane_update_o;
         end

         cur_ready_o              <= (state_s == S_ACCUM);
         post_spiking_now_o       <= (state_s == S_FIRE);
         this_sample_done_o       <= (state_s == S_FIRE) && last_step_s;
         spike_valid_o            <= (state_s == S_SETTLE);
         timestep_o               <= (state_s == S_SETTLE) ? count_r : TS_ZERO;
         surrogate_compute_time_o <= (state_s == S_SURR);
         surrogate_ref_o          <= (state_s == S_SURR) ? surrogate_ref_i : SUR_ZERO;
         surr_valid_o             <= (state_s == S_READ);
         busy_o                   <= (state_s != S_IDLE);

         // On the start edge the flag is not latched yet, so take it from the input.
         if (state_s == S_IDLE) begin
            training_state_o <= 1'b0;
         end else if (state_r == S_IDLE) begin
            training_state_o <= training_state_i;
         end else begin
            training_state_o <= training_r;
         end
      end
   end

endmodule

// File: tb/tb_neuron_layer2_sequencer.sv
// Self-checking bench for neuron_layer2_sequencer with a behavioural neuron
// (threshold 100, halving leak, reset-to-zero on spike, surrogate box) and a
// sample-level expectation model built from the word list of each sample.
module tb_neuron_layer2_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start_i;
   logic [3:0]  num_timesteps_i;
   logic        training_state_i;
   logic [2:0]  surrogate_ref_i;
   logic        cur_valid_i;
   logic        cur_ready_o;
   logic [15:0] cur_data_i;
   logic        cur_last_i;
   logic [15:0] membrane_i;
   logic        post_spike_i;
   logic [2:0]  surrogate_i;
   logic [15:0] membrane_update_o;
   logic        membrane_update_valid_o;
   logic        post_spiking_now_o;
   logic        this_sample_done_o;
   logic        training_state_o;
   logic        surrogate_compute_time_o;
   logic        surrogate_read_finish_o;
   logic [2:0]  surrogate_ref_o;
   logic        spike_valid_o;
   logic        spike_o;
   logic [3:0]  timestep_o;
   logic        surr_valid_o;
   logic        surr_ready_i;
   logic [2:0]  surr_data_o;
   logic        busy_o;

   neuron_layer2_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start_i(start_i),
      .num_timesteps_i(num_timesteps_i), .training_state_i(training_state_i),
      .surrogate_ref_i(surrogate_ref_i), .cur_valid_i(cur_valid_i),
      .cur_ready_o(cur_ready_o), .cur_data_i(cur_data_i), .cur_last_i(cur_last_i),
      .membrane_i(membrane_i), .post_spike_i(post_spike_i), .surrogate_i(surrogate_i),
      .membrane_update_o(membrane_update_o), .membrane_update_valid_o(membrane_update_valid_o),
      .post_spiking_now_o(post_spiking_now_o), .this_sample_done_o(this_sample_done_o),
      .training_state_o(training_state_o), .surrogate_compute_time_o(surrogate_compute_time_o),
      .surrogate_read_finish_o(surrogate_read_finish_o), .surrogate_ref_o(surrogate_ref_o),
      .spike_valid_o(spike_valid_o), .spike_o(spike_o), .timestep_o(timestep_o),
      .surr_valid_o(surr_valid_o), .surr_ready_i(surr_ready_i), .surr_data_o(surr_data_o),
      .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural neuron: threshold 100, membrane halves when it does not fire.
   logic signed [15:0] nmem;
   logic               npost;
   logic [2:0]         nbox;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nmem <= 16'sd0; npost <= 1'b0; nbox <= 3'd0;
      end else begin
         if (membrane_update_valid_o) nmem <= $signed(membrane_update_o);
         else if (post_spiking_now_o) begin
            if (nmem >= 16'sd100) begin npost <= 1'b1; nmem <= 16'sd0; end
            else begin npost <= 1'b0; nmem <= nmem >>> 1; end
         end
         if (surrogate_compute_time_o) nbox <= surrogate_ref_o;
         else if (surrogate_read_finish_o) nbox <= 3'd0;
      end
   end
   assign membrane_i   = nmem;
   assign post_spike_i = npost;
   assign surrogate_i  = nbox;

   typedef struct { int data; bit last; } word_t;
   word_t wq[$];

   int exp_upd[$];
   int exp_spk[$];
   int exp_ts[$];
   int exp_done[$];
   int exp_surr;
   int model_mem;
   bit cur_trn;
   bit chk_en;

   int obs_upd[$];
   int obs_spk[$];
   int obs_ts[$];
   int done_cnt;
   int last_surr;

   int pass_cnt;
   int total_cnt;

   task automatic check(input string name, input longint act, input longint exp_v);
      total_cnt++;
      if (act == exp_v) pass_cnt++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
   endtask

   task automatic stop_timeout(input string what);
      total_cnt++;
      $display("FAIL timeout_%s: event did not occur within the cycle budget", what);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "bench stopped on timeout");
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Compare process: every cycle, DUT outputs against the expectation queues.
   always @(negedge clk) begin
      if (reset_n && chk_en) begin
         if (membrane_update_valid_o) begin
            obs_upd.push_back(int'($signed(membrane_update_o)));
            if (exp_upd.size() == 0) check("update_extra", 0, 1);
            else check("membrane_update", $signed(membrane_update_o), exp_upd.pop_front());
         end
         if (spike_valid_o) begin
            obs_spk.push_back(int'(spike_o));
            obs_ts.push_back(int'(timestep_o));
            if (exp_spk.size() == 0) check("spike_extra", 0, 1);
            else begin
               check("spike", spike_o, exp_spk.pop_front());
               check("timestep", timestep_o, exp_ts.pop_front());
            end
         end
         if (post_spiking_now_o) begin
            check("fire_vs_update", membrane_update_valid_o, 0);
            if (exp_done.size() == 0) check("fire_extra", 0, 1);
            else check("sample_done", this_sample_done_o, exp_done.pop_front());
         end
         if (this_sample_done_o) begin
            done_cnt++;
            check("done_outside_fire", post_spiking_now_o, 1);
         end
         if (surr_valid_o) begin
            last_surr = int'(surr_data_o);
            check("surr_data", surr_data_o, exp_surr);
         end
         if (surrogate_compute_time_o) check("surr_ref", surrogate_ref_o, exp_surr);
         if (surrogate_read_finish_o) check("compute_vs_finish", surrogate_compute_time_o, 0);
         check("training_state", training_state_o, busy_o ? int'(cur_trn) : 0);
      end
   end

   function automatic int rand_word();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0: return 32767;
         1: return -32768;
         2: return ($urandom_range(0, 1) == 0) ? 25000 : -25000;
         default: return int'($urandom_range(0, 160)) - 40;
      endcase
   endfunction

   task automatic all_outputs_zero(input string name);
      check(name, |{cur_ready_o, membrane_update_o, membrane_update_valid_o, post_spiking_now_o,
                    this_sample_done_o, training_state_o, surrogate_compute_time_o,
                    surrogate_read_finish_o, surrogate_ref_o, spike_valid_o, spike_o,
                    timestep_o, surr_valid_o, surr_data_o, busy_o}, 0);
   endtask

   // One full sample: build expectations from wq, drive it, read out, wait for idle.
   task automatic do_sample(input int t_cfg, input bit trn, input int ref_v,
                            input int gap_min, input int gap_max, input int hold,
                            input bit inject_start, input bit abort_read);
      int t_eff, idx, acc, g, budget, d;
      bit spk;
      obs_upd.delete(); obs_spk.delete(); obs_ts.delete();
      done_cnt = 0; last_surr = -1;
      t_eff = (t_cfg == 0) ? 1 : t_cfg;
      idx = 0;
      for (int t = 0; t < t_eff; t++) begin
         acc = model_mem;
         while (1) begin
            acc = sat16(acc + wq[idx].data);
            exp_upd.push_back(acc);
            idx++;
            if (wq[idx-1].last) break;
         end
         spk = (acc >= 100);
         exp_spk.push_back(int'(spk));
         exp_ts.push_back(t);
         exp_done.push_back(int'(t == t_eff - 1));
         model_mem = spk ? 0 : (acc >>> 1);
      end
      exp_surr = ref_v;
      cur_trn = trn;

      num_timesteps_i = t_cfg[3:0]; training_state_i = trn; surrogate_ref_i = ref_v[2:0];
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      check("busy_after_start", busy_o, 1);

      for (int i = 0; i < wq.size(); i++) begin
         g = $urandom_range(gap_min, gap_max);
         cur_valid_i = 1'b0;
         for (int k = 0; k < g; k++) begin
            if (inject_start && i == 1 && k == 0) begin
               start_i = 1'b1; num_timesteps_i = 4'd7; training_state_i = ~trn;
            end
            @(posedge clk); #1;
            start_i = 1'b0; num_timesteps_i = t_cfg[3:0]; training_state_i = trn;
         end
         d = wq[i].data;
         cur_valid_i = 1'b1; cur_data_i = d[15:0]; cur_last_i = wq[i].last;
         budget = 0;
         while (!cur_ready_o) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 40) stop_timeout("cur_ready");
         end
         @(posedge clk); #1;
      end
      cur_valid_i = 1'b0; cur_last_i = 1'b0;

      if (trn) begin
         budget = 0;
         while (!surr_valid_o) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 40) stop_timeout("surr_valid");
         end
         if (abort_read) begin
            repeat (2) begin @(posedge clk); #1; end
            reset_n = 1'b0;
            #1;
            all_outputs_zero("outputs_in_reset");
            exp_upd.delete(); exp_spk.delete(); exp_ts.delete(); exp_done.delete();
            model_mem = 0; cur_trn = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            repeat (3) begin
               @(posedge clk); #1;
               all_outputs_zero("outputs_after_release");
            end
            return;
         end
         for (int k = 0; k < hold; k++) begin
            check("surr_valid_held", surr_valid_o, 1);
            @(posedge clk); #1;
         end
         check("surr_valid_at_ready", surr_valid_o, 1);
         surr_ready_i = 1'b1;
         @(posedge clk); #1;
         surr_ready_i = 1'b0;
      end

      budget = 0;
      while (busy_o) begin
         @(posedge clk); #1;
         budget++;
         if (budget > 60) stop_timeout("busy_low");
      end
      check("updates_left", exp_upd.size(), 0);
      check("spikes_left", exp_spk.size(), 0);
      check("done_pulses", done_cnt, 1);
      check("neuron_membrane", nmem, model_mem);
   endtask

   task automatic push_word(input int d, input bit l);
      word_t w;
      w.data = d; w.last = l;
      wq.push_back(w);
   endtask

   initial begin
      int t_cfg, t_eff, nw;
      pass_cnt = 0; total_cnt = 0; chk_en = 1'b0; model_mem = 0; cur_trn = 1'b0;
      reset_n = 1'b0; start_i = 1'b0; num_timesteps_i = 4'd0; training_state_i = 1'b0;
      surrogate_ref_i = 3'd0; cur_valid_i = 1'b0; cur_data_i = 16'd0; cur_last_i = 1'b0;
      surr_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      all_outputs_zero("reset_outputs");
      reset_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // 1: T=1 inference, 40 then 70 -> fires at 110
      wq.delete(); push_word(40, 0); push_word(70, 1);
      do_sample(1, 0, 0, 0, 0, 0, 0, 0);
      check("t1_upd0", obs_upd[0], 40);
      check("t1_upd1", obs_upd[1], 110);
      check("t1_spike", obs_spk[0], 1);
      check("t1_membrane", nmem, 0);
      check("t1_busy", busy_o, 0);

      // 2: T=3, one word of 60 per step -> 60, 90, 105 with leak
      wq.delete(); push_word(60, 1); push_word(60, 1); push_word(60, 1);
      do_sample(3, 0, 0, 0, 1, 0, 0, 0);
      check("t2_upd1", obs_upd[1], 90);
      check("t2_upd2", obs_upd[2], 105);
      check("t2_spikes", obs_spk[0] * 100 + obs_spk[1] * 10 + obs_spk[2], 1);
      check("t2_ts2", obs_ts[2], 2);

      // 3: saturation at both rails
      wq.delete(); push_word(32767, 0); push_word(5, 1);
      do_sample(1, 0, 0, 0, 0, 0, 0, 0);
      check("t3_pos_sat", obs_upd[1], 32767);
      wq.delete(); push_word(-32768, 0); push_word(-1, 1);
      do_sample(1, 0, 0, 0, 0, 0, 0, 0);
      check("t3_neg_sat", obs_upd[1], -32768);

      // 4: training readout with ready held low 4 cycles
      wq.delete(); push_word(120, 1);
      do_sample(1, 1, 5, 0, 0, 4, 0, 0);
      check("t4_surr_data", last_surr, 5);
      check("t4_box_cleared", nbox, 0);

      // 5: start pulse during ACCUM ignored, 3-cycle valid gaps, T=0 treated as 1 afterwards
      wq.delete(); push_word(10, 0); push_word(20, 1); push_word(30, 1);
      do_sample(2, 0, 0, 3, 3, 0, 1, 0);
      wq.delete(); push_word(7, 1);
      do_sample(0, 0, 0, 0, 0, 0, 0, 0);
      check("t5_t0_one_step", obs_spk.size(), 1);

      // 6: reset during READ, then a clean sample from a zero membrane
      wq.delete(); push_word(50, 1);
      do_sample(1, 1, 3, 0, 0, 0, 0, 1);
      wq.delete(); push_word(100, 1); push_word(5, 1);
      do_sample(2, 0, 0, 0, 0, 0, 0, 0);
      check("t6_upd0", obs_upd[0], 100);
      check("t6_upd1", obs_upd[1], 5);
      check("t6_spikes", obs_spk[0] * 10 + obs_spk[1], 10);

      // Randomized samples
      for (int s = 0; s < 30; s++) begin
         t_cfg = $urandom_range(0, 4);
         t_eff = (t_cfg == 0) ? 1 : t_cfg;
         wq.delete();
         for (int t = 0; t < t_eff; t++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) push_word(rand_word(), w == nw - 1);
         end
         do_sample(t_cfg, $urandom_range(0, 1), $urandom_range(0, 7), 0, 2,
                   $urandom_range(0, 3), $urandom_range(0, 3) == 0, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
